// File: rtl/change_dispenser.sv
// Coin payout unit: pays a refund greedily in 10/5/1 coins over a valid/ready
// hopper handshake, tracking per-denomination inventory with saturating refill.
module change_dispenser #(
   parameter int INV_W   = 6,
   parameter int INIT_10 = 10,
   parameter int INIT_5  = 10,
   parameter int INIT_1  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       req_amount,
   output logic             coin_valid,
   input  logic             coin_ready,
   output logic [3:0]       coin_value,
   input  logic             refill_valid,
   input  logic [1:0]       refill_denom,
   input  logic [INV_W-1:0] refill_count,
   output logic             done,
   output logic [5:0]       paid_total,
   output logic [5:0]       shortfall,
   output logic [INV_W-1:0] inv_10,
   output logic [INV_W-1:0] inv_5,
   output logic [INV_W-1:0] inv_1
);

   typedef enum logic [1:0] {IDLE, PICK, ISSUE, DONE} state_t;

   state_t           state_q, state_d;
   logic [5:0]       rem_q, rem_d, paid_q, paid_d;
   logic [5:0]       paid_total_q, paid_total_d, shortfall_q, shortfall_d;
   logic [3:0]       coin_value_q, coin_value_d;
   logic             req_ready_q, coin_valid_q, done_q;
   logic [INV_W-1:0] inv_10_q, inv_5_q, inv_1_q;
   logic [3:0]       pick;
   logic             hs;

   // Inventory update: handshake decrement plus refill, clamped at the counter maximum.
   function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] inv,
                                                 input logic             dec,
                                                 input logic [INV_W-1:0] add);
      logic [INV_W:0] sum;
      sum = {1'b0, inv} - {{INV_W{1'b0}}, dec} + {1'b0, add};
      if (sum[INV_W]) return '1;
      return sum[INV_W-1:0];
   endfunction

   assign hs = coin_valid_q & coin_ready;

   always_comb begin
      pick = 4'd0;
      if (rem_q >= 6'd10 && inv_10_q != '0)     pick = 4'd10;
      else if (rem_q >= 6'd5 && inv_5_q != '0)  pick = 4'd5;
      else if (rem_q != 6'd0 && inv_1_q != '0)  pick = 4'd1;
   end

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      paid_d       = paid_q;
      coin_value_d = coin_value_q;
      paid_total_d = paid_total_q;
      shortfall_d  = shortfall_q;
      case (state_q)
         IDLE: if (req_valid) begin
            rem_d   = req_amount;
            paid_d  = 6'd0;
            state_d = (req_amount == 6'd0) ? DONE : PICK;
         end
         PICK: if (pick == 4'd0) state_d = DONE;
               else begin
                  coin_value_d = pick;
                  state_d      = ISSUE;
               end
         ISSUE: if (coin_ready) begin
            rem_d        = rem_q - {2'b00, coin_value_q};
            paid_d       = paid_q + {2'b00, coin_value_q};
            coin_value_d = 4'd0;
            state_d      = (rem_d == 6'd0) ? DONE : PICK;
         end
         default: state_d = IDLE;
      endcase
      // Results are captured on entry so they appear together with the done pulse.
      if (state_d == DONE && state_q != DONE) begin
         paid_total_d = paid_d;
         shortfall_d  = rem_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rem_q        <= '0;
         paid_q       <= '0;
         coin_value_q <= '0;
         paid_total_q <= '0;
         shortfall_q  <= '0;
         req_ready_q  <= 1'b1;
         coin_valid_q <= 1'b0;
         done_q       <= 1'b0;
         inv_10_q     <= INV_W'(INIT_10);
         inv_5_q      <= INV_W'(INIT_5);
         inv_1_q      <= INV_W'(INIT_1);
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         paid_q       <= paid_d;
         coin_value_q <= coin_value_d;
         paid_total_q <= paid_total_d;
         shortfall_q  <= shortfall_d;
         req_ready_q  <= (state_d == IDLE);
         coin_valid_q <= (state_d == ISSUE);
         done_q       <= (state_d == DONE);
         inv_10_q     <= inv_next(inv_10_q, hs && coin_value_q == 4'd10,
                                  (refill_valid && refill_denom == 2'd2) ? refill_count : '0);
         inv_5_q      <= inv_next(inv_5_q, hs && coin_value_q == 4'd5,
                                  (refill_valid && refill_denom == 2'd1) ? refill_count : '0);
         inv_1_q      <= inv_next(inv_1_q, hs && coin_value_q == 4'd1,
                                  (refill_valid && refill_denom == 2'd0) ? refill_count : '0);
      end
   end

   assign req_ready  = req_ready_q;
   assign coin_valid = coin_valid_q;
   assign coin_value = coin_value_q;
   assign done       = done_q;
   assign paid_total = paid_total_q;
   assign shortfall  = shortfall_q;
   assign inv_10     = inv_10_q;
   assign inv_5      = inv_5_q;
   assign inv_1      = inv_1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: default-inventory unit A and a
// short-inventory unit B share clock, reset and request/hopper stimulus.
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid, coin_ready, refill_valid, sel;
   logic [5:0] req_amount, refill_count;
   logic [1:0] refill_denom;

   logic       a_rr, a_cv, a_done, b_rr, b_cv, b_done;
   logic [3:0] a_val, b_val;
   logic [5:0] a_paid, a_short, b_paid, b_short;
   logic [5:0] a_i10, a_i5, a_i1, b_i10, b_i5, b_i1;

   int checks = 0;
   int failures = 0;
   int got[$];
   int exp_q[$];
   int first_cv, done_k, d_paid, d_short;

   always #5 clk = ~clk;

   change_dispenser dut_a (
      .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(a_rr),
      .req_amount(req_amount), .coin_valid(a_cv), .coin_ready(coin_ready), .coin_value(a_val),
      .refill_valid(refill_valid), .refill_denom(refill_denom), .refill_count(refill_count),
      .done(a_done), .paid_total(a_paid), .shortfall(a_short),
      .inv_10(a_i10), .inv_5(a_i5), .inv_1(a_i1));

   change_dispenser #(.INV_W(6), .INIT_10(1), .INIT_5(0), .INIT_1(3)) dut_b (
      .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(b_rr),
      .req_amount(req_amount), .coin_valid(b_cv), .coin_ready(coin_ready), .coin_value(b_val),
      .refill_valid(1'b0), .refill_denom(2'd0), .refill_count(6'd0),
      .done(b_done), .paid_total(b_paid), .shortfall(b_short),
      .inv_10(b_i10), .inv_5(b_i5), .inv_1(b_i1));

   wire       o_cv    = sel ? b_cv : a_cv;
   wire       o_done  = sel ? b_done : a_done;
   wire [3:0] o_val   = sel ? b_val : a_val;
   wire [5:0] o_paid  = sel ? b_paid : a_paid;
   wire [5:0] o_short = sel ? b_short : a_short;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issues one request with the hopper always ready; records coins and done timing.
   task automatic run_req(input int amt);
      got.delete();
      first_cv = -1;
      done_k   = -1;
      chk("ready_before_req", int'(sel ? b_rr : a_rr), 1);
      req_amount = 6'(amt);
      req_valid  = 1'b1;
      coin_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (o_cv && first_cv < 0) first_cv = k;
         if (o_cv && coin_ready) got.push_back(int'(o_val));
         if (o_done) begin
            done_k  = k;
            d_paid  = int'(o_paid);
            d_short = int'(o_short);
            break;
         end
         tick();
      end
      chk("done_within_budget", int'(done_k >= 0), 1);
      chk("paid_plus_short", d_paid + d_short, amt);
      coin_ready = 1'b0;
      tick();
   endtask

   task automatic chk_coins(input string tag);
      chk({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk({tag, "_coin"}, (i < got.size()) ? got[i] : -1, exp_q[i]);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; coin_ready = 1'b0; sel = 1'b0;
      req_amount = '0; refill_valid = 1'b0; refill_denom = '0; refill_count = '0;
      tick(); tick();
      chk("rst_req_ready", int'(a_rr), 1);
      chk("rst_coin_valid", int'(a_cv), 0);
      chk("rst_coin_value", int'(a_val), 0);
      chk("rst_done", int'(a_done), 0);
      chk("rst_paid", int'(a_paid), 0);
      chk("rst_short", int'(a_short), 0);
      chk("rst_inv10", int'(a_i10), 10);
      chk("rst_inv5", int'(a_i5), 10);
      chk("rst_inv1", int'(a_i1), 10);
      chk("rst_b_inv", int'({b_i10, b_i5, b_i1}), int'({6'd1, 6'd0, 6'd3}));
      reset = 1'b0;
      tick();

      // Request 37, hopper always ready
      run_req(37);
      exp_q = '{10, 10, 10, 5, 1, 1};
      chk_coins("r37");
      chk("r37_first_cv_k", first_cv, 1);
      chk("r37_done_k", done_k, 12);
      chk("r37_paid", d_paid, 37);
      chk("r37_short", d_short, 0);
      chk("r37_inv10", int'(a_i10), 7);
      chk("r37_inv5", int'(a_i5), 9);
      chk("r37_inv1", int'(a_i1), 8);

      // Backpressure on the first coin of request 10
      req_amount = 6'd10; req_valid = 1'b1; coin_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      chk("bp_pick_no_valid", int'(a_cv), 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid_held", int'(a_cv), 1);
         chk("bp_value_held", int'(a_val), 10);
         chk("bp_inv10_held", int'(a_i10), 7);
         if (i < 4) tick();
      end
      coin_ready = 1'b1;
      tick();
      coin_ready = 1'b0;
      chk("bp_done", int'(a_done), 1);
      chk("bp_valid_drop", int'(a_cv), 0);
      chk("bp_inv10", int'(a_i10), 6);
      chk("bp_paid", int'(a_paid), 10);
      chk("bp_short", int'(a_short), 0);
      tick();
      chk("bp_idle", int'(a_rr), 1);
      chk("bp_done_pulse", int'(a_done), 0);

      // Zero request; req_valid held through DONE
      req_amount = 6'd0; req_valid = 1'b1;
      tick();
      chk("z_done", int'(a_done), 1);
      chk("z_paid", int'(a_paid), 0);
      chk("z_short", int'(a_short), 0);
      chk("z_no_coin", int'(a_cv), 0);
      chk("z_not_ready", int'(a_rr), 0);
      tick();
      req_valid = 1'b0;
      chk("z_idle_after", int'(a_rr), 1);
      chk("z_done_one_cycle", int'(a_done), 0);
      tick();

      // Shortage on unit B
      sel = 1'b1;
      run_req(15);
      exp_q = '{10, 1, 1, 1};
      chk_coins("s15");
      chk("s15_paid", d_paid, 13);
      chk("s15_short", d_short, 2);
      chk("s15_inv", int'({b_i10, b_i5, b_i1}), 0);
      run_req(4);
      exp_q = {};
      chk_coins("s4");
      chk("s4_paid", d_paid, 0);
      chk("s4_short", d_short, 4);
      chk("s4_done_k", done_k, 1);
      chk("s4_hold_short", int'(b_short), 4);
      sel = 1'b0;

      // Bring inv_1 to 5, then refill 1s during a 1-coin handshake
      run_req(3);
      exp_q = '{1, 1, 1};
      chk_coins("r3");
      chk("r3_inv1", int'(a_i1), 5);
      req_amount = 6'd1; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      chk("rf_coin1", int'(a_val), 1);
      coin_ready = 1'b1; refill_valid = 1'b1; refill_denom = 2'd0; refill_count = 6'd3;
      tick();
      coin_ready = 1'b0; refill_valid = 1'b0;
      chk("rf_inv1_same_cycle", int'(a_i1), 7);
      chk("rf_done", int'(a_done), 1);
      tick();

      // Saturating refill of 10s and ignored denomination 3
      refill_valid = 1'b1; refill_denom = 2'd2; refill_count = 6'd54;
      tick();
      chk("sat_inv10_60", int'(a_i10), 60);
      refill_count = 6'd10;
      tick();
      chk("sat_inv10_63", int'(a_i10), 63);
      refill_denom = 2'd3; refill_count = 6'd5;
      tick();
      refill_valid = 1'b0;
      chk("d3_inv10", int'(a_i10), 63);
      chk("d3_inv5", int'(a_i5), 9);
      chk("d3_inv1", int'(a_i1), 7);

      // Reset during ISSUE of the second coin of request 25
      req_amount = 6'd25; req_valid = 1'b1;
      tick();
      req_valid = 1'b0; coin_ready = 1'b1;
      tick();
      tick();
      coin_ready = 1'b0;
      chk("rm_inv10_after_hs", int'(a_i10), 62);
      tick();
      chk("rm_in_issue", int'(a_cv), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rm_cv", int'(a_cv), 0);
      chk("rm_ready", int'(a_rr), 1);
      chk("rm_done", int'(a_done), 0);
      chk("rm_inv", int'({a_i10, a_i5, a_i1}), int'({6'd10, 6'd10, 6'd10}));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rm_quiet", int'({a_cv, a_done}), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin payout unit; the outbound counterpart of the coin-accepting vending front end.
- Takes a refund amount from the vending controller and issues physical coins (10, 5, 1) one at a time to a coin hopper over a valid/ready handshake.
- Tracks per-denomination inventory, supports refill, and reports amount paid and any shortfall.

Parameters:
- INV_W, 6, width of each inventory counter; maximum inventory per denomination is 2^INV_W-1.
- INIT_10, 10, inventory of 10-unit coins after reset.
- INIT_5, 10, inventory of 5-unit coins after reset.
- INIT_1, 10, inventory of 1-unit coins after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- req_valid  in  1  refund request valid.
- req_ready  out  1  block can accept a request.
- req_amount  in  6  refund amount, 0..63.
- coin_valid  out  1  coin offered to hopper.
- coin_ready  in  1  hopper accepts the offered coin.
- coin_value  out  4  denomination offered: 10, 5 or 1; 0 when coin_valid=0.
- refill_valid  in  1  inventory refill strobe.
- refill_denom  in  2  refill target: 0=1-unit, 1=5-unit, 2=10-unit, 3=ignored.
- refill_count  in  INV_W  number of coins added.
- done  out  1  one-cycle pulse when a request completes.
- paid_total  out  6  amount paid for the last completed request.
- shortfall  out  6  amount not paid for the last completed request.
- inv_10, inv_5, inv_1  out  INV_W  current inventories.

Behaviour:
- Reset values: state IDLE, coin_valid=0, coin_value=0, done=0, paid_total=0, shortfall=0, inv_10/5/1 = INIT_10/5/1, internal remaining=0, paid=0.
- Reset mid-operation aborts the request. No further coins are issued, and inventory returns to INIT values (coins already handshaked are lost).
- States:
  - IDLE: req_ready=1. On req_valid, latch remaining=req_amount and paid=0. If req_amount=0, go to DONE; otherwise go to PICK.
  - PICK, one cycle: select the largest d in {10,5,1} with d<=remaining and inv_d>0. If none, go to DONE. Otherwise register coin_value=d and go to ISSUE.
  - ISSUE: coin_valid=1. coin_value is held stable until the handshake (coin_valid&coin_ready). On handshake: remaining-=d, paid+=d, inv_d-=1. Go to DONE if the new remaining=0, else to PICK.
  - DONE, one cycle: done=1, paid_total=paid, shortfall=remaining. Then go to IDLE.
- req_ready=0 in PICK, ISSUE and DONE. req_valid in those states is ignored; the requester must hold it.
- All outputs are registered.
- Latency: request accepted at cycle T, PICK at T+1, coin_valid first high at T+2. Each further coin adds 2 cycles (PICK + ISSUE) when coin_ready is held high.
- Zero request: done at T+1 with no coin_valid.
- paid_total and shortfall hold their values until the next DONE.
- Invariant at every DONE: paid_total + shortfall = latched req_amount.
- coin_ready while coin_valid=0 is ignored.
- Refill:
  - Accepted in any state.
  - inv_d_next = min(inv_d - dec + refill_count, 2^INV_W-1), where dec=1 if the same cycle is a handshake on denomination d.
  - refill_denom=3: no effect.
  - A refill applied during PICK is visible to that PICK's selection from the next cycle onward; PICK uses registered inventory.
- Greedy selection is the defined behaviour; no backtracking.

Test Plan:
- Default params; req 37 -> coins 10,10,10,5,1,1 (coin_ready=1). done with paid_total=37, shortfall=0; inv_10=7, inv_5=9, inv_1=8. First coin_valid exactly 2 cycles after acceptance.
- Backpressure: during the first coin of req 10, coin_ready=0 for 5 cycles -> coin_valid stays 1, coin_value stays 10, inv_10 unchanged. On release, one handshake only, then done.
- Shortage: INIT_10=1, INIT_5=0, INIT_1=3; req 15 -> coins 10,1,1,1. paid_total=13, shortfall=2, all of inv_10/5/1 = 0. Next req 4 -> done, no coins, shortfall=4.
- Zero request: req 0 -> done one cycle after acceptance, paid_total=0, shortfall=0, coin_valid never high. req_valid held during DONE is not accepted until IDLE.
- Refill:
  - inv_1=5; handshake on a 1-coin in the same cycle as a refill of 1s with count 3 -> inv_1=7.
  - INV_W=6, inv_10=60, refill 10 -> inv_10=63 (saturated).
- Reset mid-ISSUE (req 25, after the first handshake) -> next cycle coin_valid=0, state IDLE with req_ready=1, inventories back to INIT, done not pulsed.
